// File: rtl/ras.sv
// ras: circular return address stack with checkpoint/restore for fetch prediction
module ras #(
   parameter int RAS_ENTRIES      = 8,
   parameter int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES),
   parameter int RAS_TARGET_WIDTH = 31
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic                        link_valid,
   input  logic [RAS_TARGET_WIDTH-1:0] link_target,
   input  logic                        ret_valid,
   output logic [RAS_TARGET_WIDTH-1:0] ras_target,
   output logic [LOG_RAS_ENTRIES-1:0]  ras_index,
   output logic [LOG_RAS_ENTRIES:0]    ras_count,
   output logic                        ras_empty,
   input  logic                        restore_valid,
   input  logic [LOG_RAS_ENTRIES-1:0]  restore_index,
   input  logic [LOG_RAS_ENTRIES:0]    restore_count
);
   localparam logic [LOG_RAS_ENTRIES:0] FULL = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);
   logic [RAS_TARGET_WIDTH-1:0] entry [RAS_ENTRIES];
   logic [LOG_RAS_ENTRIES-1:0]  ptr;
   logic [LOG_RAS_ENTRIES:0]    cnt;
   assign ras_target = entry[ptr];
   assign ras_index  = ptr;
   assign ras_count  = cnt;
   assign ras_empty  = cnt == '0;
   // stack update: reset > restore > push+pop replace > push > pop
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         ptr <= '0;
         cnt <= '0;
         for (int i = 0; i < RAS_ENTRIES; i++) entry[i] <= '0;
      end else if (restore_valid) begin
         ptr <= restore_index;
         cnt <= restore_count;
      end else if (link_valid && ret_valid) begin
         entry[ptr] <= link_target;
      end else if (link_valid) begin
         ptr <= ptr + 1'b1;
         entry[ptr + 1'b1] <= link_target;
         cnt <= cnt == FULL ? FULL : cnt + 1'b1;
      end else if (ret_valid) begin
         ptr <= ptr - 1'b1;
         cnt <= cnt == '0 ? '0 : cnt - 1'b1;
      end
   end
endmodule

// File: tb/tb_ras.sv
// tb_ras: scoreboard bench for ras with directed plan cases and random traffic
module tb_ras;
   logic        CLK = 0;
   logic        nRST = 0;
   logic        link_valid = 0;
   logic [30:0] link_target = '0;
   logic        ret_valid = 0;
   logic [30:0] ras_target;
   logic [2:0]  ras_index;
   logic [3:0]  ras_count;
   logic        ras_empty;
   logic        restore_valid = 0;
   logic [2:0]  restore_index = '0;
   logic [3:0]  restore_count = '0;

   typedef struct {logic [30:0] t; int i; int c; logic e;} exp_t;
   exp_t        sb[$];
   logic [30:0] m [8];
   int          mp, mc;
   bit          stim_done = 0;
   int          n_cmp = 0, n_bad = 0;

   ras dut (
      .CLK(CLK), .nRST(nRST), .link_valid(link_valid), .link_target(link_target),
      .ret_valid(ret_valid), .ras_target(ras_target), .ras_index(ras_index),
      .ras_count(ras_count), .ras_empty(ras_empty), .restore_valid(restore_valid),
      .restore_index(restore_index), .restore_count(restore_count)
   );

   always #5 CLK = ~CLK;

   // drive one cycle of requests, then advance the reference stack and queue its expected view
   task automatic step(input logic rn, input logic lv, input logic [30:0] lt, input logic rt,
                       input logic rs, input logic [2:0] ri, input logic [3:0] rc);
      nRST = rn; link_valid = lv; link_target = lt; ret_valid = rt;
      restore_valid = rs; restore_index = ri; restore_count = rc;
      @(posedge CLK);
      if (!rn) begin
         mp = 0; mc = 0;
         for (int k = 0; k < 8; k++) m[k] = '0;
      end else if (rs) begin
         mp = ri; mc = rc;
      end else if (lv && rt) begin
         m[mp] = lt;
      end else if (lv) begin
         mp = (mp + 1) % 8; m[mp] = lt; mc = (mc + 1 > 8) ? 8 : mc + 1;
      end else if (rt) begin
         mp = (mp + 7) % 8; mc = (mc > 0) ? mc - 1 : 0;
      end
      sb.push_back('{m[mp], mp, mc, mc == 0});
      #1;
   endtask

   task automatic push(input logic [30:0] t); step(1, 1, t, 0, 0, 0, 0); endtask
   task automatic pop();                      step(1, 0, 0, 1, 0, 0, 0); endtask
   task automatic rst();                      step(0, 0, 0, 0, 0, 0, 0); endtask

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
      end
   endfunction

   // monitor: compare presented outputs against the oldest expectation every cycle
   initial begin
      int cyc = 0;
      exp_t e;
      while (!(stim_done && sb.size() == 0)) begin
         @(negedge CLK);
         cyc++;
         if (cyc > 20000) begin
            n_bad++;
            $display("FAIL timeout: %0d expectations left, required 0", sb.size());
            break;
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ras_target", {1'b0, ras_target}, {1'b0, e.t});
            chk("ras_index", {29'd0, ras_index}, e.i);
            chk("ras_count", {28'd0, ras_count}, e.c);
            chk("ras_empty", {31'd0, ras_empty}, {31'd0, e.e});
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // stimulus: test-plan scenarios followed by random traffic with occasional restores and resets
   initial begin
      rst(); rst();
      push(31'h1000); step(1, 0, 0, 0, 0, 0, 0); pop(); step(1, 0, 0, 0, 0, 0, 0);
      rst();
      for (int k = 1; k <= 9; k++) push(31'(k));
      for (int k = 0; k < 8; k++) pop();
      rst(); pop(); pop(); push(31'h55);
      rst(); push(31'h1); push(31'hA); step(1, 1, 31'hB, 1, 0, 0, 0);
      rst(); push(31'h11); push(31'h22); push(31'h33);
      push(31'h44); push(31'h55);
      step(1, 1, 31'hDEAD, 0, 1, 3'd3, 4'd3);
      step(1, 0, 0, 0, 1, 3'd4, 4'd4);
      push(31'h66); step(0, 1, 31'h77, 0, 0, 0, 0); pop();
      for (int n = 0; n < 600; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         step(r != 0, r < 45 || (r >= 85 && r < 92), 31'($urandom),
              r >= 45 && r < 92, r >= 92, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 8)));
      end
      stim_done = 1;
   end
endmodule
